cdda_sequencer: RTL and testbench
=================================

# cdda_sequencer

Playback controller for the CD-DA sample FIFO: moves raw 2352-byte audio sectors from the CD sector loader into the FIFO as 16-bit words and generates the 44.1 kHz sample-read strobe that drains it. Sits between the CD loader/sector buffer and the CDDA FIFO, driving the FIFO's WRITE/DIN/READ pins and obeying its WRITE_READY sector-space flag. Play, pause and stop are applied here; the FIFO itself stays a dumb buffer.

## Interface
Parameters:
- CLK_HZ, 48000000, system clock frequency.
- SAMPLE_HZ, 44100, stereo sample rate.
- WORDS_PER_SECTOR, 1176, 16-bit words per audio sector (2352/2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- PLAY  in  1  level; 1 = playback enabled.
- PAUSE  in  1  level; 1 = suspend sample reads.
- SRC_SECTOR_RDY  in  1  loader holds a complete sector.
- SRC_REQ  out  1  word request to loader.
- SRC_ACK  in  1  loader word valid; SRC_DATA sampled this cycle.
- SRC_DATA  in  16  sector word, little-endian sample order.
- SECTOR_DONE  out  1  one-cycle pulse after last word of a sector is written.
- CDDA_WRITE  out  1  FIFO write strobe (rising-edge sensitive).
- CDDA_DOUT  out  16  FIFO write data.
- CDDA_WRITE_READY  in  1  FIFO has room for one full sector.
- CDDA_READ  out  1  FIFO sample-read strobe.
- PLAYING  out  1  1 when not IDLE.
- STARVE  out  1  sticky starvation flag.

## Operation
- States: IDLE, WAIT_SECTOR, FETCH, STROBE, GAP.
- IDLE: PLAY=1 -> WAIT_SECTOR; STARVE cleared on this transition.
- WAIT_SECTOR: PLAY=0 -> IDLE; else SRC_SECTOR_RDY=1 and CDDA_WRITE_READY=1 -> FETCH, word counter := 0.
- FETCH: SRC_REQ=1; on SRC_ACK capture SRC_DATA into CDDA_DOUT, SRC_REQ drops same edge -> STROBE.
- STROBE: CDDA_WRITE=1 for exactly one cycle, CDDA_DOUT stable -> GAP.
- GAP: CDDA_WRITE=0; counter == WORDS_PER_SECTOR-1 -> pulse SECTOR_DONE, -> WAIT_SECTOR; else counter+1, -> FETCH.
- PLAY/PAUSE never abort a sector in progress; PLAY=0 takes effect at the next WAIT_SECTOR. Keeps even/odd (L/R) word pairing aligned with FIFO.
- Sample tick: phase accumulator acc (32 bit); each cycle acc += SAMPLE_HZ; if result >= CLK_HZ, subtract CLK_HZ and assert tick. Accumulator runs in every state.
- CDDA_READ = registered tick AND PLAYING AND ~PAUSE; one cycle wide.
- STARVE set on a gated tick while in WAIT_SECTOR with CDDA_WRITE_READY=1 and SRC_SECTOR_RDY=0.
- Pause does not stop fetching; FIFO backpressure (WRITE_READY=0) halts it naturally.

## Timing
- Reset values: SRC_REQ, SECTOR_DONE, CDDA_WRITE, CDDA_READ, PLAYING, STARVE = 0; CDDA_DOUT = 0; acc = 0; state IDLE.
- Reset mid-sector: immediate IDLE, counter 0, partial sector abandoned; loader reset jointly.
- Word cost: minimum 3 cycles (FETCH with same-cycle ACK, STROBE, GAP); sector >= 3528 cycles.
- SRC_ACK ignored when SRC_REQ=0.
- CDDA_WRITE never high on consecutive cycles; minimum one low cycle between pulses.
- CDDA_READ period: floor/ceil of CLK_HZ/SAMPLE_HZ cycles (1088/1089 at defaults), long-run exact.
- SECTOR_DONE asserts in the GAP cycle of the last word.
- Simultaneous tick and CDDA_WRITE allowed; FIFO handles both.

## Configuration
- CDDA_SEQ_LBA_EN defined: adds inputs START_LBA (24) and LBA_LOAD (1-cycle pulse) and output CUR_LBA (24, reset 0). LBA_LOAD loads START_LBA; SECTOR_DONE increments CUR_LBA, wrap at 2^24. LBA_LOAD wins over simultaneous increment.
- Undefined: ports and counter absent; all other behaviour identical.

## Structure
- Package cdda_pkg: state enum, WORDS_PER_SECTOR default, sector byte size constant, LBA width.
- Sub-module cdda_rate_gen: phase accumulator, parameters CLK_HZ/SAMPLE_HZ, output tick.

## Test plan
- Reset then PLAY=1, SRC_SECTOR_RDY=1, WRITE_READY=1, ACK same cycle -> exactly 1176 CDDA_WRITE pulses, 3-cycle spacing, one SECTOR_DONE, data matches SRC_DATA order.
- CLK_HZ=48000000, run 480000 cycles playing -> 441 CDDA_READ pulses (±1), spacing 1088/1089.
- PAUSE=1 mid-sector -> CDDA_READ stops next cycle, writes continue to sector end; PAUSE=0 resumes reads.
- PLAY=0 at word 500 -> remaining 676 words written, then IDLE, PLAYING=0, no further SRC_REQ.
- WRITE_READY=1, SRC_SECTOR_RDY=0 during playing tick -> STARVE=1, held until next IDLE->WAIT_SECTOR.
- nRESET low at word 300 -> all outputs 0 asynchronously; with CDDA_SEQ_LBA_EN, LBA_LOAD 0x0000FF then two sectors -> CUR_LBA 0x000101.

Source files
------------

// File: rtl/cdda_pkg.sv
// Shared types and constants for the CD-DA playback sequencer.
package cdda_pkg;

    localparam int SECTOR_BYTES         = 2352;
    localparam int WORDS_PER_SECTOR_DEF = SECTOR_BYTES / 2;
    localparam int LBA_W                = 24;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SECTOR,
        FETCH,
        STROBE,
        GAP
    } seq_state_t;

endpackage

// File: rtl/cdda_rate_gen.sv
// Fractional sample-rate tick generator: one-cycle tick at SAMPLE_HZ from a CLK_HZ clock.
module cdda_rate_gen #(
    parameter int unsigned CLK_HZ    = 48000000,
    parameter int unsigned SAMPLE_HZ = 44100
) (
    input  logic CLK,
    input  logic nRESET,
    output logic tick
);

    logic [31:0] acc;
    logic [32:0] sum;

    always_comb begin
        sum = {1'b0, acc} + 33'(SAMPLE_HZ);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= 33'(CLK_HZ)) begin
            acc  <= 32'(sum - 33'(CLK_HZ));
            tick <= 1'b1;
        end else begin
            acc  <= sum[31:0];
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/cdda_sequencer.sv
// CD-DA playback sequencer: sector loader -> CDDA FIFO writes plus 44.1 kHz read strobe.
// Optional LBA tracking counter enabled by defining CDDA_SEQ_LBA_EN.
//
// state       | meaning
// IDLE        | playback off, no requests
// WAIT_SECTOR | playing, waiting for a loaded sector and FIFO sector space
// FETCH       | word requested from loader, waiting for SRC_ACK
// STROBE      | FIFO write strobe high, data held on CDDA_DOUT
// GAP         | strobe low; advance word counter or finish sector
module cdda_sequencer
    import cdda_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 48000000,
    parameter int unsigned SAMPLE_HZ        = 44100,
    parameter int          WORDS_PER_SECTOR = WORDS_PER_SECTOR_DEF
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             PLAY,
    input  logic             PAUSE,
    input  logic             SRC_SECTOR_RDY,
    output logic             SRC_REQ,
    input  logic             SRC_ACK,
    input  logic [15:0]      SRC_DATA,
    output logic             SECTOR_DONE,
    output logic             CDDA_WRITE,
    output logic [15:0]      CDDA_DOUT,
    input  logic             CDDA_WRITE_READY,
    output logic             CDDA_READ,
    output logic             PLAYING,
`ifdef CDDA_SEQ_LBA_EN
    input  logic [LBA_W-1:0] START_LBA,
    input  logic             LBA_LOAD,
    output logic [LBA_W-1:0] CUR_LBA,
`endif
    output logic             STARVE
);

    localparam int CNT_W = $clog2(WORDS_PER_SECTOR);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_SECTOR - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] word_cnt;
    logic             tick;
    logic             read_gate;

    cdda_rate_gen #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_rate_gen (
        .CLK    (CLK),
        .nRESET (nRESET),
        .tick   (tick)
    );

    assign read_gate = tick & PLAYING & ~PAUSE;

    // PLAY/PAUSE are only sampled in IDLE/WAIT_SECTOR so a sector is never split,
    // keeping the L/R word pairing in the FIFO aligned.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            word_cnt    <= '0;
            SRC_REQ     <= 1'b0;
            SECTOR_DONE <= 1'b0;
            CDDA_WRITE  <= 1'b0;
            CDDA_DOUT   <= '0;
            PLAYING     <= 1'b0;
        end else begin
            SECTOR_DONE <= 1'b0;
            CDDA_WRITE  <= 1'b0;
            case (state)
                IDLE: begin
                    if (PLAY) begin
                        state   <= WAIT_SECTOR;
                        PLAYING <= 1'b1;
                    end
                end
                WAIT_SECTOR: begin
                    if (!PLAY) begin
                        state   <= IDLE;
                        PLAYING <= 1'b0;
                    end else if (SRC_SECTOR_RDY && CDDA_WRITE_READY) begin
                        state    <= FETCH;
                        word_cnt <= '0;
                        SRC_REQ  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (SRC_ACK) begin
                        CDDA_DOUT  <= SRC_DATA;
                        SRC_REQ    <= 1'b0;
                        CDDA_WRITE <= 1'b1;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    state       <= GAP;
                    SECTOR_DONE <= (word_cnt == LAST_WORD);
                end
                GAP: begin
                    if (word_cnt == LAST_WORD) begin
                        state <= WAIT_SECTOR;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        SRC_REQ  <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state   <= IDLE;
                    SRC_REQ <= 1'b0;
                    PLAYING <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            CDDA_READ <= 1'b0;
            STARVE    <= 1'b0;
        end else begin
            CDDA_READ <= read_gate;
            if (state == IDLE && PLAY) begin
                STARVE <= 1'b0;
            end else if (read_gate && state == WAIT_SECTOR &&
                         CDDA_WRITE_READY && !SRC_SECTOR_RDY) begin
                STARVE <= 1'b1;
            end
        end
    end

`ifdef CDDA_SEQ_LBA_EN
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            CUR_LBA <= '0;
        end else if (LBA_LOAD) begin
            CUR_LBA <= START_LBA;
        end else if (SECTOR_DONE) begin
            CUR_LBA <= CUR_LBA + LBA_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cdda_sequencer.sv
// Directed self-checking bench for cdda_sequencer (covers CDDA_SEQ_LBA_EN when defined).
module tb_cdda_sequencer;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b1;
    logic        PLAY = 1'b0;
    logic        PAUSE = 1'b0;
    logic        SRC_SECTOR_RDY = 1'b0;
    logic        SRC_ACK = 1'b0;
    logic [15:0] SRC_DATA = '0;
    logic        CDDA_WRITE_READY = 1'b0;
    logic        SRC_REQ, SECTOR_DONE, CDDA_WRITE, CDDA_READ, PLAYING, STARVE;
    logic [15:0] CDDA_DOUT;
`ifdef CDDA_SEQ_LBA_EN
    logic [23:0] START_LBA = '0;
    logic        LBA_LOAD = 1'b0;
    logic [23:0] CUR_LBA;
`endif

    int errors = 0;
    int checks = 0;

    cdda_sequencer dut (
        .CLK              (CLK),
        .nRESET           (nRESET),
        .PLAY             (PLAY),
        .PAUSE            (PAUSE),
        .SRC_SECTOR_RDY   (SRC_SECTOR_RDY),
        .SRC_REQ          (SRC_REQ),
        .SRC_ACK          (SRC_ACK),
        .SRC_DATA         (SRC_DATA),
        .SECTOR_DONE      (SECTOR_DONE),
        .CDDA_WRITE       (CDDA_WRITE),
        .CDDA_DOUT        (CDDA_DOUT),
        .CDDA_WRITE_READY (CDDA_WRITE_READY),
        .CDDA_READ        (CDDA_READ),
        .PLAYING          (PLAYING),
`ifdef CDDA_SEQ_LBA_EN
        .START_LBA        (START_LBA),
        .LBA_LOAD         (LBA_LOAD),
        .CUR_LBA          (CUR_LBA),
`endif
        .STARVE           (STARVE)
    );

    always #5 CLK = ~CLK;

    // Loader model: acknowledges every request in the same FETCH cycle.
    int unsigned src_idx;
    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) src_idx <= 0;
        else if (SRC_REQ && SRC_ACK) src_idx <= src_idx + 1;
    end
    always @(negedge CLK) begin
        SRC_ACK  = SRC_REQ;
        SRC_DATA = src_idx[15:0] ^ 16'h5A5A;
    end

    int  cyc = 0, wr_cnt = 0, wr_in_sec = 0, done_cnt = 0, read_cnt = 0, req_cyc = 0;
    int  data_err = 0, consec_err = 0, space_err = 0, len_err = 0, rd_space_err = 0;
    int  last_wr = 0, last_rd = 0;
    bit  prev_wr = 0, meas_en = 0, last_rd_valid = 0;

    always @(negedge CLK) begin
        cyc++;
        if (!nRESET) begin
            wr_cnt = 0; wr_in_sec = 0; done_cnt = 0; prev_wr = 0;
        end else begin
            if (CDDA_WRITE) begin
                if (CDDA_DOUT !== (wr_cnt[15:0] ^ 16'h5A5A)) data_err++;
                if (prev_wr) consec_err++;
                if (wr_in_sec != 0 && (cyc - last_wr) != 3) space_err++;
                last_wr = cyc;
                wr_cnt++;
                wr_in_sec++;
            end
            if (SECTOR_DONE) begin
                done_cnt++;
                if (wr_in_sec != 1176) len_err++;
                wr_in_sec = 0;
            end
            prev_wr = CDDA_WRITE;
            if (CDDA_READ) begin
                read_cnt++;
                if (meas_en && last_rd_valid &&
                    (cyc - last_rd) != 1088 && (cyc - last_rd) != 1089) rd_space_err++;
                last_rd = cyc;
                last_rd_valid = meas_en;
            end
            if (SRC_REQ) req_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #2;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #2;
    endtask

    int r0, w0, base;

    initial begin
        #1 nRESET = 1'b0;
        cyc_wait(3);
        check("rst_req",     SRC_REQ,     0);
        check("rst_done",    SECTOR_DONE, 0);
        check("rst_write",   CDDA_WRITE,  0);
        check("rst_read",    CDDA_READ,   0);
        check("rst_playing", PLAYING,     0);
        check("rst_starve",  STARVE,      0);
        check("rst_dout",    CDDA_DOUT,   0);
`ifdef CDDA_SEQ_LBA_EN
        check("rst_lba",     CUR_LBA,     0);
`endif

        // Sector 1, PLAY dropped at word 500: sector still completes
        nRESET = 1'b1;
        SRC_SECTOR_RDY = 1'b1;
        CDDA_WRITE_READY = 1'b1;
        PLAY = 1'b1;
        cyc_wait(2);
        check("playing_on", PLAYING, 1);
        wait_wr(500, 3000);
        PLAY = 1'b0;
        wait_done(1, 4000);
        cyc_wait(20);
        check("s1_writes",   wr_cnt,     1176);
        check("s1_done",     done_cnt,   1);
        check("s1_data",     data_err,   0);
        check("s1_consec",   consec_err, 0);
        check("s1_spacing",  space_err,  0);
        check("s1_playing",  PLAYING,    0);
        check("s1_starve",   STARVE,     0);
        r0 = req_cyc;
        cyc_wait(100);
        check("idle_no_req", req_cyc, r0);

        // Continuous playback: read rate over a 22000-cycle window
        PLAY = 1'b1;
        meas_en = 1'b1;
        r0 = read_cnt;
        cyc_wait(22000);
        meas_en = 1'b0;
        check("rate_count", ((read_cnt - r0) == 20 || (read_cnt - r0) == 21), 1);
        check("rate_space", rd_space_err, 0);

        // Pause: reads stop, writes continue
        PAUSE = 1'b1;
        cyc_wait(1);
        r0 = read_cnt;
        w0 = wr_cnt;
        cyc_wait(1500);
        check("pause_no_read", read_cnt, r0);
        check("pause_writes",  (wr_cnt > w0), 1);
        check("pause_playing", PLAYING, 1);
        PAUSE = 1'b0;
        r0 = read_cnt;
        cyc_wait(1200);
        check("resume_reads", (read_cnt > r0), 1);

        // Starvation: loader empty while FIFO has room
        SRC_SECTOR_RDY = 1'b0;
        wait_done(done_cnt + 1, 4000);
        cyc_wait(2500);
        check("starve_set",     STARVE,  1);
        check("starve_playing", PLAYING, 1);
        r0 = req_cyc;
        cyc_wait(50);
        check("starve_no_req", req_cyc, r0);
        CDDA_WRITE_READY = 1'b0;
        PLAY = 1'b0;
        cyc_wait(5);
        check("stop_playing", PLAYING, 0);
        check("starve_held",  STARVE,  1);
        PLAY = 1'b1;
        cyc_wait(3);
        check("starve_clear", STARVE,  0);
        check("replay",       PLAYING, 1);

        // Backpressure: sector ready but no FIFO room
        SRC_SECTOR_RDY = 1'b1;
        r0 = req_cyc;
        cyc_wait(200);
        check("backpressure", req_cyc, r0);
        check("all_data",    data_err,   0);
        check("all_consec",  consec_err, 0);
        check("all_spacing", space_err,  0);
        check("all_len",     len_err,    0);

        // Reset at word 300 of a sector
        CDDA_WRITE_READY = 1'b1;
        base = wr_cnt;
        wait_wr(base + 300, 2000);
        check("pre_rst_busy", PLAYING, 1);
        #1 nRESET = 1'b0;
        #1;
        check("arst_req",     SRC_REQ,     0);
        check("arst_write",   CDDA_WRITE,  0);
        check("arst_dout",    CDDA_DOUT,   0);
        check("arst_read",    CDDA_READ,   0);
        check("arst_playing", PLAYING,     0);
        check("arst_starve",  STARVE,      0);
        check("arst_done",    SECTOR_DONE, 0);
`ifdef CDDA_SEQ_LBA_EN
        check("arst_lba",     CUR_LBA,     0);
`endif
        cyc_wait(2);
        nRESET = 1'b1;
`ifdef CDDA_SEQ_LBA_EN
        START_LBA = 24'h0000FF;
        LBA_LOAD = 1'b1;
        cyc_wait(1);
        LBA_LOAD = 1'b0;
        cyc_wait(1);
        check("lba_load", CUR_LBA, 24'h0000FF);
`endif
        // Two fresh sectors after reset; counter and loader restart from word 0
        wait_wr(1176 + 500, 5000);
        PLAY = 1'b0;
        wait_done(2, 4000);
        cyc_wait(10);
        check("post_rst_writes", wr_cnt,   2352);
        check("post_rst_done",   done_cnt, 2);
        check("post_rst_data",   data_err, 0);
        check("post_rst_len",    len_err,  0);
        check("post_rst_idle",   PLAYING,  0);
`ifdef CDDA_SEQ_LBA_EN
        check("lba_incr", CUR_LBA, 24'h000101);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
